nco_quad_gen: RTL and testbench
===============================

// Module: nco_quad_gen
// PURPOSE
//  Parametrised quadrature NCO for the carrier-offset loop; next generation of the fixed 12-bit NCO.
//  - Adds a runtime frequency control word (FCW), a phase offset and a synchronous phase clear.
//  - Uses a quarter-wave sine LUT and a 3-stage pipeline with a valid flag.
//  - Drives the derotator mixer with ncos/nsin; phase_out goes to the loop monitor.
// PARAMETERS
//  ACC_W   24  phase accumulator width; one full turn = 2^ACC_W
//  LUT_AW   8  quarter-wave LUT address bits (2^LUT_AW entries)
//  OUT_W   12  signed two's-complement output width; amplitude A = 2^(OUT_W-1)-1
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          asynchronous reset, active-low
//  en         in   1          advance the accumulator and issue one sample
//  fcw_ld     in   1          load fcw into the FCW register
//  fcw        in   ACC_W      frequency control word (unsigned, modulo 2^ACC_W)
//  phase_ofs  in   ACC_W      static phase offset; sampled every cycle
//  sync_clr   in   1          clear the accumulator to 0
//  out_valid  out  1          ncos/nsin/phase_out valid this cycle
//  ncos       out  OUT_W      cosine sample, signed
//  nsin       out  OUT_W      sine sample, signed
//  phase_out  out  ACC_W      phase (acc + phase_ofs) that produced the current sample
// BEHAVIOUR
//  - Reset (rst=0, async): acc=0, fcw_r=0, all pipeline registers 0.
//    Outputs after reset: out_valid=0, ncos=0, nsin=0, phase_out=0.
//  - FCW register: fcw_r <= fcw when fcw_ld=1, regardless of en.
//  - Accumulator:
//    - sync_clr=1 -> acc <= 0 (overrides en).
//    - else en=1 -> acc <= acc + fcw_r, modulo 2^ACC_W; wrap is silent.
//    - fcw_ld and sync_clr in the same cycle: both take effect; the first add after the clear uses the new fcw_r.
//  - Stage 1 (en=1):
//    - ph = acc + phase_ofs (mod 2^ACC_W).
//    - q = ph[ACC_W-1:ACC_W-2].
//    - a = ph[ACC_W-3 -: LUT_AW]; lower bits truncated.
//  - Stage 2: LUT read.
//    - LUT[k] = round(A*sin(2*pi*(k+0.5)/(4*2^LUT_AW))), k = 0..2^LUT_AW-1; all entries positive.
//    - Read LUT[a] and LUT[~a] in parallel.
//  - Stage 3, sin by quadrant:
//    - q0 -> +LUT[a]; q1 -> +LUT[~a]; q2 -> -LUT[a]; q3 -> -LUT[~a].
//    - cos uses the same map with quadrant (q+1) mod 4.
//  - Latency: the acc value present on the en cycle appears on outputs 3 clk later with out_valid=1.
//  - out_valid is a 3-deep shift of en. When en=0, a bubble propagates; outputs hold their last value; out_valid=0.
//  - sync_clr does not flush the pipeline: in-flight samples still complete.
//  - Outputs never exceed +/-A; no saturation logic is needed.
// CONFIGURATION
//  NCO_DITHER_EN defined:
//    - A 16-bit Galois LFSR (poly x^16+x^14+x^13+x^11+1, seed 16'hACE1, reset to seed) steps on each en.
//    - Its low (ACC_W-2-LUT_AW) bits are added to ph before truncation; spurs are spread.
//    - Latency unchanged.
//  NCO_DITHER_EN undefined: no LFSR; plain truncation; outputs bit-exact to the LUT map above.
// TESTING (defaults ACC_W=24, LUT_AW=8, OUT_W=12, A=2047; dither off unless noted)
//  1. Reset: hold rst=0 for 3 cycles -> ncos=nsin=0, out_valid=0, phase_out=0; release at negedge, en=1.
//     -> out_valid rises on the 3rd posedge after en.
//  2. fcw=0, phase_ofs=0 -> ncos=2047, nsin=6 steady; phase_out=0.
//  3. fcw_ld with fcw=24'h400000 (quarter turn per sample):
//     -> nsin sequence 6, 2047, -6, -2047, repeating.
//     -> ncos sequence 2047, -6, -2047, 6; acc wraps to 0 every 4 samples.
//  4. fcw=24'h400000, toggle en 1-0-1 -> out_valid shows a one-cycle gap 3 cycles later.
//     -> outputs hold through the gap; the sequence resumes without skipping a phase.
//  5. Mid-run sync_clr=1 together with fcw_ld fcw=24'h200000:
//     -> 3 in-flight samples complete, then phase_out = 0, 200000, 400000 (hex).
//     -> nsin = 6, then LUT[255-... mirrored], then 2047 at 400000.
//  6. phase_ofs=24'h800000, fcw=0 -> nsin=-6, ncos=-2047.
//     With NCO_DITHER_EN: same mean, but the nsin LSBs vary; |nsin|,|ncos| <= 2047.

Source files
------------

// File: rtl/nco_quad_gen.sv
// Quadrature NCO: runtime FCW, phase offset, sync clear, quarter-wave LUT, 3-stage pipeline.
// Optional build macro NCO_DITHER_EN adds LFSR phase dither ahead of LUT address truncation.
module nco_quad_gen #(
    parameter int ACC_W  = 24,
    parameter int LUT_AW = 8,
    parameter int OUT_W  = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             fcw_ld,
    input  logic [ACC_W-1:0] fcw,
    input  logic [ACC_W-1:0] phase_ofs,
    input  logic             sync_clr,
    output logic             out_valid,
    output logic [OUT_W-1:0] ncos,
    output logic [OUT_W-1:0] nsin,
    output logic [ACC_W-1:0] phase_out
);

    localparam int LUT_N   = 1 << LUT_AW;
    localparam int AMP     = (1 << (OUT_W - 1)) - 1;
    localparam int TRUNC_W = ACC_W - 2 - LUT_AW;

    // Quarter-wave table sampled at bin centres; built at elaboration from a Taylor series.
    function automatic logic [LUT_N*OUT_W-1:0] gen_lut();
        real pi_c;
        real x;
        real term;
        real s;
        logic [LUT_N*OUT_W-1:0] tbl;
        tbl  = '0;
        pi_c = 3.14159265358979323846;
        for (int k = 0; k < LUT_N; k++) begin
            x    = 2.0 * pi_c * (real'(k) + 0.5) / (4.0 * real'(LUT_N));
            term = x;
            s    = x;
            for (int n = 1; n <= 12; n++) begin
                term = -term * x * x / real'((2 * n) * (2 * n + 1));
                s    = s + term;
            end
            tbl[k*OUT_W +: OUT_W] = OUT_W'($rtoi(real'(AMP) * s + 0.5));
        end
        return tbl;
    endfunction

    localparam logic [LUT_N*OUT_W-1:0] LUT = gen_lut();

    function automatic logic [OUT_W-1:0] lut_read(input logic [LUT_AW-1:0] idx);
        return LUT[int'(idx)*OUT_W +: OUT_W];
    endfunction

    function automatic logic signed [OUT_W-1:0] quad_map(
        input logic [1:0]       q,
        input logic [OUT_W-1:0] mag_a,
        input logic [OUT_W-1:0] mag_na
    );
        case (q)
            2'd0:    return  $signed(mag_a);
            2'd1:    return  $signed(mag_na);
            2'd2:    return -$signed(mag_a);
            default: return -$signed(mag_na);
        endcase
    endfunction

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] fcw_r;
    logic [ACC_W-1:0] ph;
    logic [ACC_W-1:0] ph_addr;
    logic [ACC_W-1:0] dith;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fcw_r <= '0;
        end else if (fcw_ld) begin
            fcw_r <= fcw;
        end
    end

    // A clear wins over en; the add after a clear picks up any fcw loaded alongside it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (sync_clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + fcw_r;
        end
    end

`ifdef NCO_DITHER_EN
    localparam logic [ACC_W-1:0] DITH_MASK = (ACC_W'(1) << TRUNC_W) - ACC_W'(1);
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= 16'hACE1;
        end else if (en) begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign dith = ACC_W'(lfsr) & DITH_MASK;
`else
    assign dith = '0;
`endif

    assign ph      = acc + phase_ofs;
    assign ph_addr = ph + dith;

    // ---- stage 1: phase, quadrant and LUT address ----
    logic                 vld_p1;
    logic [1:0]           q_p1;
    logic [LUT_AW-1:0]    a_p1;
    logic [ACC_W-1:0]     ph_p1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1 <= 1'b0;
            q_p1   <= '0;
            a_p1   <= '0;
            ph_p1  <= '0;
        end else begin
            vld_p1 <= en;
            if (en) begin
                q_p1  <= ph_addr[ACC_W-1 -: 2];
                a_p1  <= ph_addr[ACC_W-3 -: LUT_AW];
                ph_p1 <= ph;
            end
        end
    end

    // ---- stage 2: parallel LUT read of a and its mirror ----
    logic                 vld_p2;
    logic [1:0]           q_p2;
    logic [OUT_W-1:0]     mag_a_p2;
    logic [OUT_W-1:0]     mag_na_p2;
    logic [ACC_W-1:0]     ph_p2;
    logic [LUT_AW-1:0]    na_p1;

    assign na_p1 = ~a_p1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p2    <= 1'b0;
            q_p2      <= '0;
            mag_a_p2  <= '0;
            mag_na_p2 <= '0;
            ph_p2     <= '0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                q_p2      <= q_p1;
                mag_a_p2  <= lut_read(a_p1);
                mag_na_p2 <= lut_read(na_p1);
                ph_p2     <= ph_p1;
            end
        end
    end

    // ---- stage 3: quadrant fold; cosine is sine one quadrant ahead ----
    logic                       vld_p3;
    logic signed [OUT_W-1:0]    nsin_p3;
    logic signed [OUT_W-1:0]    ncos_p3;
    logic [ACC_W-1:0]           ph_p3;
    logic [1:0]                 qc_p2;

    assign qc_p2 = q_p2 + 2'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p3  <= 1'b0;
            nsin_p3 <= '0;
            ncos_p3 <= '0;
            ph_p3   <= '0;
        end else begin
            vld_p3 <= vld_p2;
            if (vld_p2) begin
                nsin_p3 <= quad_map(q_p2, mag_a_p2, mag_na_p2);
                ncos_p3 <= quad_map(qc_p2, mag_a_p2, mag_na_p2);
                ph_p3   <= ph_p2;
            end
        end
    end

    assign out_valid = vld_p3;
    assign nsin      = nsin_p3;
    assign ncos      = ncos_p3;
    assign phase_out = ph_p3;

endmodule

// File: tb/tb_nco_quad_gen.sv
// Scoreboard bench for nco_quad_gen: model predicts round(A*sin/cos) at the centre of each phase bin.
module tb_nco_quad_gen;

    localparam int    ACC_W  = 24;
    localparam int    LUT_AW = 8;
    localparam int    OUT_W  = 12;
    localparam real   PI     = 3.14159265358979323846;
    localparam real   AMPL   = 2047.0;
    localparam int    BINS   = 4 << LUT_AW;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             fcw_ld;
    logic [ACC_W-1:0] fcw;
    logic [ACC_W-1:0] phase_ofs;
    logic             sync_clr;
    logic             out_valid;
    logic [OUT_W-1:0] ncos;
    logic [OUT_W-1:0] nsin;
    logic [ACC_W-1:0] phase_out;

    nco_quad_gen #(.ACC_W(ACC_W), .LUT_AW(LUT_AW), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .fcw_ld(fcw_ld), .fcw(fcw),
        .phase_ofs(phase_ofs), .sync_clr(sync_clr), .out_valid(out_valid),
        .ncos(ncos), .nsin(nsin), .phase_out(phase_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ACC_W-1:0] ph;
        int               s;
        int               c;
    } exp_t;

    exp_t             sb[$];
    exp_t             mon_e;
    int               n_cmp = 0;
    int               n_bad = 0;
    logic [ACC_W-1:0] m_acc;
    logic [ACC_W-1:0] m_fcw;
    logic [ACC_W-1:0] cur_ofs;
    bit               seen = 1'b0;
    exp_t             last_e;

    task automatic check(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
        end
    endtask

    function automatic exp_t make_exp(input logic [ACC_W-1:0] ph);
        exp_t r;
        int   bin;
        real  ang;
        bin  = int'(ph >> (ACC_W - 2 - LUT_AW));
        ang  = 2.0 * PI * (real'(bin) + 0.5) / real'(BINS);
        r.ph = ph;
        r.s  = $rtoi($floor(AMPL * $sin(ang) + 0.5));
        r.c  = $rtoi($floor(AMPL * $cos(ang) + 0.5));
        return r;
    endfunction

    task automatic cycle(input bit e, input bit ld, input logic [ACC_W-1:0] f,
                         input logic [ACC_W-1:0] o, input bit c);
        en        = e;
        fcw_ld    = ld;
        fcw       = f;
        phase_ofs = o;
        sync_clr  = c;
        if (e) sb.push_back(make_exp(m_acc + o));
        if (c)      m_acc = '0;
        else if (e) m_acc = m_acc + m_fcw;
        if (ld)     m_fcw = f;
        @(posedge clk);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_valid actual=1 required=0 at %0t", $time);
                end else begin
                    mon_e = sb.pop_front();
                    check("phase_out", int'(phase_out), int'(mon_e.ph));
                    check("nsin", int'($signed(nsin)), mon_e.s);
                    check("ncos", int'($signed(ncos)), mon_e.c);
                    last_e = mon_e;
                    seen   = 1'b1;
                end
            end else if (seen) begin
                check("hold_nsin", int'($signed(nsin)), last_e.s);
                check("hold_ncos", int'($signed(ncos)), last_e.c);
                check("hold_phase", int'(phase_out), int'(last_e.ph));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; en = 1'b0; fcw_ld = 1'b0; fcw = '0; phase_ofs = '0; sync_clr = 1'b0;
        m_acc = '0; m_fcw = '0; cur_ofs = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", int'(out_valid), 0);
        check("rst_ncos", int'($signed(ncos)), 0);
        check("rst_nsin", int'($signed(nsin)), 0);
        check("rst_phase", int'(phase_out), 0);
        rst = 1'b1;

        // latency: valid only after the third edge following en
        cycle(1, 0, '0, '0, 0);
        check("lat_edge1", int'(out_valid), 0);
        cycle(1, 0, '0, '0, 0);
        check("lat_edge2", int'(out_valid), 0);
        cycle(1, 0, '0, '0, 0);
        check("lat_edge3", int'(out_valid), 1);
        check("dc_nsin", int'($signed(nsin)), 6);
        check("dc_ncos", int'($signed(ncos)), 2047);
        repeat (4) cycle(1, 0, '0, '0, 0);

        // quarter turn per sample
        cycle(1, 1, 24'h400000, '0, 0);
        repeat (12) cycle(1, 0, 24'h400000, '0, 0);

        // en gaps
        cycle(1, 0, '0, '0, 0);
        cycle(0, 0, '0, '0, 0);
        cycle(1, 0, '0, '0, 0);
        cycle(0, 0, '0, '0, 0);
        cycle(0, 0, '0, '0, 0);
        repeat (6) cycle(1, 0, '0, '0, 0);

        // clear together with a new fcw
        cycle(1, 1, 24'h200000, '0, 1);
        repeat (8) cycle(1, 0, '0, '0, 0);

        // half-turn offset at rest
        cycle(1, 1, '0, 24'h800000, 1);
        repeat (5) cycle(1, 0, '0, 24'h800000, 0);
        check("ofs_nsin", int'($signed(nsin)), -6);
        check("ofs_ncos", int'($signed(ncos)), -2047);
        check("ofs_phase", int'(phase_out), 32'h800000);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit               e;
            bit               ld;
            bit               c;
            logic [ACC_W-1:0] f;
            e  = ($urandom_range(0, 3) != 0);
            ld = ($urandom_range(0, 15) == 0);
            c  = ($urandom_range(0, 31) == 0);
            f  = ACC_W'($urandom);
            if ($urandom_range(0, 7) == 0) cur_ofs = ACC_W'($urandom);
            cycle(e, ld, f, cur_ofs, c);
        end

        repeat (5) cycle(0, 0, '0, cur_ofs, 0);
        check("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
